// File: rtl/trigger_out_pkg.sv
// Shared constants and helpers for the trigger-out event latch.
package trigger_out_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned SUM_W     = CNT_W + 1;
  // Widest event vector the popcount helper accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_MAX_W = 64;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Number of set bits in v.
  function automatic logic [CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/trigger_out_latch_edge.sv
// Rising-edge detector for the event lines. The history register resets to all
// ones so a line already high when reset releases is not reported as an event.
module evt_edge_detect #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] evt_in,
  output logic [WIDTH-1:0] edges
);

  logic [WIDTH-1:0] evt_q;

  // Register the event lines once for edge comparison.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      evt_q <= '1;
    end else begin
      evt_q <= evt_in;
    end
  end

  // A bit is an edge when it is high now and was low last cycle.
  always_comb begin
    edges = evt_in & ~evt_q;
  end

endmodule

// File: rtl/trigger_out_latch.sv
// Sticky event flags with host snapshot, masked clear, overflow tracking and a
// saturating event counter, all on sys_clk.
module trigger_out_latch
  import trigger_out_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter bit          AUTO_CLR = 1'b0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] evt_in,
  input  logic             snap_strb,
  input  logic             clr_strb,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] flags_out,
  output logic [WIDTH-1:0] ovf_out,
  output logic [CNT_W-1:0] evt_total,
  output logic             pending
);

  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] flags_nxt;
  logic [WIDTH-1:0] ovf_nxt;
  logic [WIDTH-1:0] clr_sel;
  logic [WIDTH-1:0] auto_sel;
  logic [WIDTH-1:0] flag_clr;
  logic [WIDTH-1:0] ovf_set;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] total_nxt;
  logic [SUM_W-1:0] sum;

  evt_edge_detect #(
    .WIDTH (WIDTH)
  ) u_edge (
    .sys_clk (sys_clk),
    .reset   (reset),
    .evt_in  (evt_in),
    .edges   (edges)
  );

  // Next-state for flags, overflow and the event counter; a set always beats a clear.
  always_comb begin
    clr_sel   = '0;
    auto_sel  = '0;
    flag_clr  = '0;
    flags_nxt = flags;
    ovf_set   = '0;
    ovf_nxt   = ovf_out;
    edge_cnt  = '0;
    sum       = '0;
    total_nxt = evt_total;

    if (clr_strb) begin
      clr_sel = clr_mask;
    end
    if (AUTO_CLR && snap_strb) begin
      auto_sel = flags;
    end
    flag_clr  = clr_sel | auto_sel;
    flags_nxt = edges | (flags & ~flag_clr);

    // An edge on an already-set flag that is not being serviced this cycle is a lost event.
    ovf_set = edges & flags & ~flag_clr;
    ovf_nxt = ovf_set | (ovf_out & ~clr_sel);

    edge_cnt = popcount(POP_MAX_W'(edges));
    sum      = SUM_W'(evt_total) + SUM_W'(edge_cnt);
    if (cnt_clr) begin
      total_nxt = edge_cnt;
    end else if (sum > SUM_W'(CNT_MAX)) begin
      total_nxt = CNT_MAX;
    end else begin
      total_nxt = sum[CNT_W-1:0];
    end
  end

  // State and output registers; the snapshot captures flags before this cycle's update.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      flags     <= '0;
      ovf_out   <= '0;
      flags_out <= '0;
      evt_total <= '0;
      pending   <= 1'b0;
    end else begin
      flags     <= flags_nxt;
      ovf_out   <= ovf_nxt;
      evt_total <= total_nxt;
      pending   <= |flags_nxt;
      if (snap_strb) begin
        flags_out <= flags;
      end
    end
  end

endmodule
